// File: rtl/gf180mcu_osu_sc_gp12t3v3__xnor2_bist_ctrl.sv
// rtl/gf180mcu_osu_sc_gp12t3v3__xnor2_bist_ctrl.sv - BIST sequencer for a bank of xnor2 cells
// Drives the four A/B vectors into every cell, samples after a settle window, accumulates failures.
module gf180mcu_osu_sc_gp12t3v3__xnor2_bist_ctrl #(
    parameter int N      = 8,
    parameter int SETTLE = 2,
    parameter int LOOPS  = 1
) (
    input  logic         CLK,
    input  logic         RN,
    input  logic         START,
    input  logic         ABORT,
    output logic [N-1:0] TA,
    output logic [N-1:0] TB,
    input  logic [N-1:0] TY,
    output logic         BUSY,
    output logic         DONE,
    output logic         PASS,
    output logic [7:0]   FAIL_CNT,
    output logic [N-1:0] FAIL_MASK
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

    localparam logic [3:0] SETTLE_W  = 4'(SETTLE);
    localparam logic [7:0] LAST_LOOP = 8'(LOOPS - 1);
    // With no settle time a freshly launched vector is sampled on the very next edge
    localparam state_t LAUNCH_STATE = (SETTLE == 0) ? S_CHECK : S_SETTLE;

    state_t       state, state_n;
    logic [3:0]   cnt, cnt_n;
    logic [1:0]   vec, vec_n;
    logic [7:0]   loop_cnt, loop_n;
    logic [N-1:0] ta_n, tb_n, mask_n, mism;
    logic [7:0]   fcnt_n;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state     <= S_IDLE;
            cnt       <= '0;
            vec       <= '0;
            loop_cnt  <= '0;
            TA        <= '0;
            TB        <= '0;
            FAIL_CNT  <= '0;
            FAIL_MASK <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            vec       <= vec_n;
            loop_cnt  <= loop_n;
            TA        <= ta_n;
            TB        <= tb_n;
            FAIL_CNT  <= fcnt_n;
            FAIL_MASK <= mask_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        vec_n   = vec;
        loop_n  = loop_cnt;
        ta_n    = TA;
        tb_n    = TB;
        fcnt_n  = FAIL_CNT;
        mask_n  = FAIL_MASK;
        mism    = TY ^ ~(TA ^ TB);
        case (state)
            S_IDLE, S_DONE: begin
                if (START) begin
                    fcnt_n  = '0;
                    mask_n  = '0;
                    vec_n   = '0;
                    loop_n  = '0;
                    ta_n    = '0;
                    tb_n    = '0;
                    cnt_n   = SETTLE_W;
                    state_n = LAUNCH_STATE;
                end
            end
            S_SETTLE: begin
                if (ABORT) begin
                    state_n = S_IDLE;
                    ta_n    = '0;
                    tb_n    = '0;
                end else begin
                    cnt_n = cnt - 4'd1;
                    if (cnt == 4'd1) state_n = S_CHECK;
                end
            end
            S_CHECK: begin
                // An abort discards the sample taken in this cycle
                if (ABORT) begin
                    state_n = S_IDLE;
                    ta_n    = '0;
                    tb_n    = '0;
                end else begin
                    if (|mism) begin
                        fcnt_n = (FAIL_CNT == 8'hFF) ? 8'hFF : FAIL_CNT + 8'd1;
                        mask_n = FAIL_MASK | mism;
                    end
                    if (vec == 2'd3 && loop_cnt == LAST_LOOP) begin
                        state_n = S_DONE;
                        ta_n    = '0;
                        tb_n    = '0;
                    end else begin
                        vec_n   = vec + 2'd1;
                        if (vec == 2'd3) loop_n = loop_cnt + 8'd1;
                        ta_n    = {N{vec_n[1]}};
                        tb_n    = {N{vec_n[0]}};
                        cnt_n   = SETTLE_W;
                        state_n = LAUNCH_STATE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign BUSY = (state == S_SETTLE) || (state == S_CHECK);
    assign DONE = (state == S_DONE);
    assign PASS = DONE && (FAIL_CNT == 8'd0);

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__xnor2_bist_ctrl.sv
// tb/tb_gf180mcu_osu_sc_gp12t3v3__xnor2_bist_ctrl.sv - scoreboard bench for the xnor2 BIST sequencer
module tb_gf180mcu_osu_sc_gp12t3v3__xnor2_bist_ctrl;

    typedef struct {
        logic [7:0] cnt;
        logic [7:0] mask;
        logic       pass;
        int         busy;
    } exp_t;

    logic       clk = 0;
    logic       rn = 0;
    logic       start1 = 0, abort1 = 0, start2 = 0, abort2 = 0;
    logic [7:0] ta1, tb1, ty1, mask1, fcnt1, ta2, tb2, ty2, mask2, fcnt2;
    logic       busy1, done1, pass1, busy2, done2, pass2;
    int         mode1 = 4, mode2 = 0;
    int         checks = 0, failures = 0;
    exp_t       q1[$], q2[$];

    always #5 clk = ~clk;

    gf180mcu_osu_sc_gp12t3v3__xnor2_bist_ctrl #(.N(8), .SETTLE(2), .LOOPS(1)) dut (
        .CLK(clk), .RN(rn), .START(start1), .ABORT(abort1), .TA(ta1), .TB(tb1), .TY(ty1),
        .BUSY(busy1), .DONE(done1), .PASS(pass1), .FAIL_CNT(fcnt1), .FAIL_MASK(mask1));

    gf180mcu_osu_sc_gp12t3v3__xnor2_bist_ctrl #(.N(8), .SETTLE(0), .LOOPS(70)) dut2 (
        .CLK(clk), .RN(rn), .START(start2), .ABORT(abort2), .TA(ta2), .TB(tb2), .TY(ty2),
        .BUSY(busy2), .DONE(done2), .PASS(pass2), .FAIL_CNT(fcnt2), .FAIL_MASK(mask2));

    // Cell bank models: 0 ideal, 1 bit3 stuck-at-0, 3 bit3 stuck plus vector 1 inverted, 4 all ones
    always_comb begin
        case (mode1)
            1:       ty1 = ~(ta1 ^ tb1) & 8'hF7;
            3:       ty1 = ((ta1 == 8'h00 && tb1 == 8'hFF) ? (ta1 ^ tb1) : ~(ta1 ^ tb1)) & 8'hF7;
            4:       ty1 = 8'hFF;
            default: ty1 = ~(ta1 ^ tb1);
        endcase
        ty2 = (mode2 == 1) ? (ta2 ^ tb2) : 8'h00;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run(input int which);
        @(negedge clk);
        if (which == 1) start1 = 1; else start2 = 1;
        @(negedge clk);
        start1 = 0;
        start2 = 0;
    endtask

    task automatic wait_done(input int which, input int max);
        int n = 0;
        while (((which == 1) ? done1 : done2) !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", (which == 1) ? done1 : done2, 1'b1);
    endtask

    initial begin : mon1
        int   bc = 0;
        logic dq = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy1) bc++;
            if (done1 && !dq) begin
                if (q1.size() == 0) chk("sb1_unexpected_done", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("sb1_fail_cnt", fcnt1, e.cnt);
                    chk("sb1_fail_mask", mask1, e.mask);
                    chk("sb1_pass", pass1, e.pass);
                    chk("sb1_busy_cycles", bc, e.busy);
                end
            end
            if (!busy1) bc = 0;
            dq = done1;
        end
    end

    initial begin : mon2
        int   bc = 0;
        logic dq = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy2) bc++;
            if (done2 && !dq) begin
                if (q2.size() == 0) chk("sb2_unexpected_done", 1, 0);
                else begin
                    e = q2.pop_front();
                    chk("sb2_fail_cnt", fcnt2, e.cnt);
                    chk("sb2_fail_mask", mask2, e.mask);
                    chk("sb2_pass", pass2, e.pass);
                    chk("sb2_busy_cycles", bc, e.busy);
                end
            end
            if (!busy2) bc = 0;
            dq = done2;
        end
    end

    initial begin
        logic [1:0] v;
        // Reset with START high and TY all ones
        start1 = 1;
        start2 = 1;
        repeat (2) @(negedge clk);
        chk("reset_outs1", {ta1, tb1, busy1, done1, pass1, fcnt1, mask1}, 0);
        chk("reset_outs2", {ta2, tb2, busy2, done2, pass2, fcnt2, mask2}, 0);
        rn = 1;
        start1 = 0;
        start2 = 0;
        @(negedge clk);
        chk("post_reset1", {ta1, tb1, busy1, done1, pass1, fcnt1, mask1}, 0);
        chk("post_reset2", {ta2, tb2, busy2, done2, pass2, fcnt2, mask2}, 0);

        // Ideal bank: vector sequence and busy window
        mode1 = 0;
        q1.push_back('{8'd0, 8'h00, 1'b1, 12});
        run(1);
        for (int i = 0; i < 12; i++) begin
            v = 2'(i / 3);
            chk("ideal_busy", busy1, 1'b1);
            chk("ideal_ta", ta1, {8{v[1]}});
            chk("ideal_tb", tb1, {8{v[0]}});
            @(negedge clk);
        end
        chk("ideal_done_edge12", {busy1, done1}, 2'b01);

        // Bit 3 stuck-at-0 fails vectors 0 and 3
        mode1 = 1;
        q1.push_back('{8'd2, 8'h08, 1'b0, 12});
        run(1);
        wait_done(1, 20);

        // Abort during vector 1 check; vector 1 sample is discarded
        mode1 = 3;
        run(1);
        repeat (5) @(negedge clk);
        abort1 = 1;
        @(negedge clk);
        abort1 = 0;
        chk("abort_state", {busy1, done1, ta1, tb1}, 0);
        chk("abort_fail_cnt", fcnt1, 8'd1);
        chk("abort_fail_mask", mask1, 8'h08);
        mode1 = 0;
        q1.push_back('{8'd0, 8'h00, 1'b1, 12});
        run(1);
        wait_done(1, 20);

        // START pulse during SETTLE is ignored
        q1.push_back('{8'd0, 8'h00, 1'b1, 12});
        run(1);
        start1 = 1;
        @(negedge clk);
        start1 = 0;
        wait_done(1, 20);

        // START held in DONE restarts and clears previous results
        mode1 = 1;
        q1.push_back('{8'd2, 8'h08, 1'b0, 12});
        run(1);
        wait_done(1, 20);
        mode1 = 0;
        q1.push_back('{8'd0, 8'h00, 1'b1, 12});
        start1 = 1;
        @(negedge clk);
        chk("restart_done_clear", done1, 1'b0);
        chk("restart_cnt_clear", {fcnt1, mask1}, 16'h0);
        repeat (2) @(negedge clk);
        start1 = 0;
        wait_done(1, 20);

        // 70 loops, no settle: TY=0 fails vectors 0/3, inverted TY saturates
        mode2 = 0;
        q2.push_back('{8'd140, 8'hFF, 1'b0, 280});
        run(2);
        wait_done(2, 400);
        mode2 = 1;
        q2.push_back('{8'd255, 8'hFF, 1'b0, 280});
        run(2);
        wait_done(2, 400);

        repeat (3) @(negedge clk);
        chk("sb1_drained", q1.size(), 0);
        chk("sb2_drained", q2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gf180mcu_osu_sc_gp12t3v3__xnor2_bist_ctrl.md
Name: gf180mcu_osu_sc_gp12t3v3__xnor2_bist_ctrl

Overview:
Built-in self-test sequencer for a bank of N xnor2_1 cells on the gp12t3v3 test chip. It drives the four A/B input combinations into every cell in parallel, waits a programmable settle time, and samples the bank outputs. It compares the samples against the expected XNOR result and reports pass/fail, a fail count and a per-cell fail mask. The block sits between the chip test controller (START/DONE handshake) and the cell bank.

Parameters:
N, 8, number of xnor2 cells in the bank (width of TA/TB/TY/FAIL_MASK), 1..64
SETTLE, 2, idle cycles between vector launch and the sample cycle, 0..15
LOOPS, 1, number of passes over the 4-vector set, 1..255

Ports:
CLK  input  1  clock, rising edge
RN  input  1  asynchronous active-low reset
START  input  1  run request, sampled only in IDLE or DONE
ABORT  input  1  cancel an active run
TA  output  N  A inputs of the bank, registered
TB  output  N  B inputs of the bank, registered
TY  input  N  Y outputs of the bank
BUSY  output  1  high while a run is active (SETTLE or CHECK)
DONE  output  1  run complete; held until the next accepted START
PASS  output  1  DONE and FAIL_CNT==0
FAIL_CNT  output  8  count of failing vector checks, saturating at 255
FAIL_MASK  output  N  sticky OR of mismatching bit positions

Behaviour:
- Reset (RN low, asynchronous): state=IDLE. TA, TB, FAIL_CNT and FAIL_MASK are 0. BUSY, DONE and PASS are 0. Vector index and loop counter are 0.
- States are IDLE, SETTLE, CHECK and DONE. BUSY=1 exactly in SETTLE and CHECK.
- Vector order v=0..3 is (A,B) = (0,0), (0,1), (1,0), (1,1). TA={N{v[1]}} and TB={N{v[0]}}. Expected Y = ~(TA^TB) bitwise.
- START accepted (IDLE or DONE, START=1), at the same edge:
  - FAIL_CNT and FAIL_MASK clear, DONE clears.
  - v=0 and the loop counter is 0; TA/TB load vector 0.
  - Next state is SETTLE with the counter set to SETTLE, or CHECK if SETTLE=0.
- SETTLE: counter decrements each cycle. Leave for CHECK at the edge where the counter is 1, so SETTLE lasts exactly SETTLE cycles.
- CHECK (one cycle), at its ending edge:
  - mism = TY ^ ~(TA^TB).
  - If mism!=0: FAIL_CNT = min(FAIL_CNT+1, 255) and FAIL_MASK |= mism.
  - If this is not the last vector of the last loop: advance v (wrap 3->0 and increment the loop counter), load the new TA/TB, and return to SETTLE (or CHECK if SETTLE=0).
  - Otherwise: go to DONE, DONE=1, and TA/TB return to 0.
- Timing: each vector is driven for SETTLE+1 cycles before its sample edge. DONE rises 4*LOOPS*(SETTLE+1) edges after the START-accept edge.
- START while BUSY is ignored.
- ABORT while BUSY: next edge goes to IDLE with TA/TB=0. DONE stays 0; FAIL_CNT and FAIL_MASK keep their partial values. ABORT has priority over a CHECK update in the same cycle (that sample is discarded).
- ABORT in IDLE or DONE has no effect.
- START and ABORT together in IDLE/DONE: START wins.
- PASS is combinational: DONE & (FAIL_CNT==0).
- TY is sampled only in CHECK; TY values in other states are don't-care.
- RN asserted mid-run: immediate return to the reset values. No result is preserved.

Test Plan:
- Reset values: pulse RN low with START=1 and TY=all-ones -> all outputs 0 during reset and one cycle after release.
- Ideal bank (TY=~(TA^TB)), N=8, SETTLE=2, LOOPS=1, START 1 cycle:
  - BUSY high for 12 cycles.
  - TA/TB step through 00/00, 00/FF, FF/00, FF/FF, 3 cycles each.
  - DONE rises 12 edges after accept; PASS=1, FAIL_CNT=0, FAIL_MASK=0x00.
- Bit 3 stuck-at-0 in TY, same config -> vectors 0 and 3 fail; FAIL_CNT=2, FAIL_MASK=0x08, PASS=0 at DONE.
- ABORT asserted in the CHECK cycle of vector 1, with TY wrong on vector 1:
  - Next cycle: IDLE, BUSY=0, DONE=0, TA/TB=0.
  - FAIL_CNT equals the count through vector 0 only.
  - A new START then runs a full 12-cycle test.
- START pulsed during SETTLE -> ignored; the run length is unchanged. START held high in DONE -> a new run starts and the previous DONE/results clear.
- LOOPS=70, SETTLE=0, TY=0 -> 280 checks, 140 failing (vectors 0 and 3 each loop); FAIL_CNT=140. With TY driven to ~expected on every check -> FAIL_CNT saturates at 255 and stays there; DONE at edge 280.
